// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_arb_pkg: shared sizes, state and select types for the 8-way round-robin arbiter
package mux8_arb_pkg;
    localparam int NREQ = 8;
    localparam int SEL_W = 3;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: producer-side request/data bundle plus downstream valid/ready channel
// Ports: req/din/out_ready driven by master; out_valid/out_data/sel/gnt/ack driven by slave (arbiter).
interface mux8_rr_arbiter_if
    import mux8_arb_pkg::*;
#(
    parameter int W = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0][W-1:0] din;
    logic out_ready;
    logic out_valid;
    logic [W-1:0] out_data;
    sel_t sel;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    modport master (output req, din, out_ready, input out_valid, out_data, sel, gnt, ack);
    modport slave (input req, din, out_ready, output out_valid, out_data, sel, gnt, ack);
endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// rr_pick8: first set request at or after ptr, searching circularly over 8 requesters
// Ports: req in 8, ptr in 3; any out (some request set), idx out 3 (winner).
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  sel_t            ptr,
    output logic            any,
    output sel_t            idx
);
    logic [NREQ-1:0] rot;
    sel_t off;
    // Rotating req so ptr lands on bit 0 turns the circular search into a lowest-set-bit search.
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? SEL_W'(i) : off;
    end
    assign any = |req;
    assign idx = ptr + off;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin, burst-bounded arbiter steering an 8:1 data mux to one valid/ready sink
// Ports: clk, rst (async, active-high); bus (slave): req/din/out_ready in, out_valid/out_data/sel/gnt/ack out.
// Optional MUX8_ARB_STATS_EN: stats_clr in (sync clear), beat_count out (saturating accepted-beat count).
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int W = 4,
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MUX8_ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] beat_count,
`endif
    mux8_rr_arbiter_if.slave bus
);
    localparam int BCW = $clog2(BURST_LEN + 1);
    arb_state_t state;
    sel_t sel, ptr, idx;
    logic [NREQ-1:0] gnt;
    logic [BCW-1:0] beat_cnt;
    logic any, valid, accept;
    rr_pick8 u_pick (.req(bus.req), .ptr(ptr), .any(any), .idx(idx));
    assign valid = (state == BUSY) && bus.req[sel];
    assign accept = valid && bus.out_ready;
    assign bus.out_valid = valid;
    assign bus.sel = sel;
    assign bus.gnt = gnt;
    assign bus.ack = accept ? gnt : '0;
    assign bus.out_data = W'(bus.din[sel]);
    // Every release (burst done or request withdrawn) returns to IDLE, giving one bubble per rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            sel <= '0;
            ptr <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                sel <= idx;
                gnt <= NREQ'(1) << idx;
                beat_cnt <= '0;
                state <= BUSY;
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BCW'(BURST_LEN - 1)) begin
                state <= IDLE;
                gnt <= '0;
                ptr <= sel + 1'b1;
            end
        end else if (!bus.req[sel]) begin
            state <= IDLE;
            gnt <= '0;
            ptr <= sel + 1'b1;
        end
    end
`ifdef MUX8_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat_count <= '0;
        else if (stats_clr) beat_count <= '0;
        else if (accept && beat_count != 16'hFFFF) beat_count <= beat_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: scenario and randomized checks of mux8_rr_arbiter against a behavioural model
module tb_mux8_rr_arbiter;
    localparam int W = 4;
    localparam int BL = 4;
    logic clk = 0;
    logic rst;
    int checks = 0;
    int passed = 0;
    mux8_rr_arbiter_if #(.W(W)) bus ();
`ifdef MUX8_ARB_STATS_EN
    logic stats_clr;
    logic [15:0] beat_count;
`endif
    mux8_rr_arbiter #(.W(W), .BURST_LEN(BL)) dut (
        .clk(clk),
        .rst(rst),
`ifdef MUX8_ARB_STATS_EN
        .stats_clr(stats_clr),
        .beat_count(beat_count),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;

    // Model: owner is the granted requester (-1 when idle), start is where the next search begins,
    // last is the most recently granted requester (the select keeps pointing at it while idle).
    int m_owner, m_start, m_last, m_beats, m_acc;
    logic [7:0] e_gnt, e_ack;
    logic [2:0] e_sel;
    logic e_valid;
    logic [W-1:0] e_data;

    function automatic void model_reset();
        m_owner = -1;
        m_start = 0;
        m_last = 0;
        m_beats = 0;
        m_acc = 0;
    endfunction

    function automatic void model_tick();
        if (m_owner < 0) begin
            for (int k = 0; k < 8; k++)
                if (m_owner < 0 && bus.req[(m_start + k) % 8]) begin
                    m_owner = (m_start + k) % 8;
                    m_last = m_owner;
                    m_beats = 0;
                end
        end else if (bus.req[m_owner] && bus.out_ready) begin
            m_acc++;
            m_beats++;
            if (m_beats == BL) begin
                m_start = (m_owner + 1) % 8;
                m_owner = -1;
            end
        end else if (!bus.req[m_owner]) begin
            m_start = (m_owner + 1) % 8;
            m_owner = -1;
        end
    endfunction

    function automatic void expect_now();
        e_gnt = (m_owner < 0) ? 8'h00 : 8'(1) << m_owner;
        e_valid = (m_owner >= 0) && bus.req[m_owner];
        e_sel = 3'(m_last);
        e_ack = (e_valid && bus.out_ready) ? e_gnt : 8'h00;
        e_data = bus.din[m_last];
    endfunction

    task automatic tick();
        model_tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
        expect_now();
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        bus.req = '0;
        bus.out_ready = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        logic [W-1:0] d0;
        rst = 1;
        model_reset();
        bus.req = '0;
        bus.out_ready = 1;
        for (int i = 0; i < 8; i++) bus.din[i] = W'($urandom);
        d0 = bus.din[0];
        #3;
        checks++;
        if ({bus.gnt, bus.sel, bus.out_valid, bus.ack} !== 20'h0) $display("FAIL reset_state: gnt/sel/valid/ack got %h/%0d/%b/%h want 00/0/0/00", bus.gnt, bus.sel, bus.out_valid, bus.ack);
        else passed++;
        checks++;
        if (bus.out_data !== d0) $display("FAIL reset_data: out_data got %h want %h", bus.out_data, d0);
        else passed++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single();
        int acks = 0;
        do_reset();
        bus.din[2] = 4'hA;
        bus.out_ready = 1;
        bus.req = 8'h04;
        tick();
        checks++;
        if (bus.gnt !== 8'h04 || bus.sel !== 3'd2 || bus.out_data !== 4'hA) $display("FAIL single_grant: gnt/sel/data got %h/%0d/%h want 04/2/a", bus.gnt, bus.sel, bus.out_data);
        else passed++;
        for (int i = 0; i < BL; i++) begin
            settle();
            checks++;
            if ({bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data} !== {e_gnt, e_sel, e_valid, e_ack, e_data})
                $display("FAIL single_beat%0d: gnt/sel/valid/ack/data got %h/%0d/%b/%h/%h want %h/%0d/%b/%h/%h", i, bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data, e_gnt, e_sel, e_valid, e_ack, e_data);
            else passed++;
            acks += int'(bus.ack[2]);
            tick();
        end
        checks++;
        if (acks != BL) $display("FAIL single_acks: got %0d want %0d", acks, BL);
        else passed++;
        checks++;
        if (bus.gnt !== 8'h00) $display("FAIL single_bubble: gnt got %h want 00", bus.gnt);
        else passed++;
        tick();
        checks++;
        if (bus.gnt !== 8'h04) $display("FAIL single_regrant: gnt got %h want 04", bus.gnt);
        else passed++;
    endtask

    task automatic test_round_robin();
        int g = 0;
        logic [7:0] prev = 8'h00;
        do_reset();
        bus.req = 8'hFF;
        bus.out_ready = 1;
        for (int c = 0; c < 150 && g < 9; c++) begin
            settle();
            checks++;
            if ({bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data} !== {e_gnt, e_sel, e_valid, e_ack, e_data})
                $display("FAIL rr_cycle%0d: gnt/sel/valid/ack/data got %h/%0d/%b/%h/%h want %h/%0d/%b/%h/%h", c, bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data, e_gnt, e_sel, e_valid, e_ack, e_data);
            else passed++;
            if (bus.gnt != 8'h00 && prev == 8'h00) begin
                checks++;
                if (bus.gnt !== 8'(1) << (g % 8)) $display("FAIL rr_order%0d: gnt got %h want %h", g, bus.gnt, 8'(1) << (g % 8));
                else passed++;
                g++;
            end
            prev = bus.gnt;
            tick();
        end
        checks++;
        if (g != 9) $display("FAIL rr_count: grants got %0d want 9", g);
        else passed++;
    endtask

    task automatic test_backpressure();
        int acks = 0;
        do_reset();
        bus.req = 8'h20;
        bus.out_ready = 0;
        tick();
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({bus.out_valid, bus.sel, bus.gnt, bus.ack} !== {1'b1, 3'd5, 8'h20, 8'h00} || dut.beat_cnt != 1)
                $display("FAIL stall%0d: valid/sel/gnt/ack/beat_cnt got %b/%0d/%h/%h/%0d want 1/5/20/00/1", i, bus.out_valid, bus.sel, bus.gnt, bus.ack, dut.beat_cnt);
            else passed++;
            tick();
        end
        bus.out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.gnt == 8'h00) break;
            acks += int'(bus.ack[5]);
            tick();
        end
        checks++;
        if (acks != BL - 1) $display("FAIL stall_remaining: acks got %0d want %0d", acks, BL - 1);
        else passed++;
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.req = 8'h08;
        bus.out_ready = 1;
        tick();
        #1;
        checks++;
        if (bus.ack !== 8'h08) $display("FAIL withdraw_ack: ack got %h want 08", bus.ack);
        else passed++;
        tick();
        bus.req = 8'h00;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 8'h00) $display("FAIL withdraw_valid: valid/ack got %b/%h want 0/00", bus.out_valid, bus.ack);
        else passed++;
        tick();
        #1;
        checks++;
        if (bus.gnt !== 8'h00 || dut.ptr !== 3'd4) $display("FAIL withdraw_idle: gnt/ptr got %h/%0d want 00/4", bus.gnt, dut.ptr);
        else passed++;
        bus.req = 8'h09;
        tick();
        #1;
        checks++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) $display("FAIL withdraw_next: gnt/sel got %h/%0d want 01/0", bus.gnt, bus.sel);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d0;
        do_reset();
        bus.req = 8'h40;
        bus.out_ready = 1;
        tick();
        tick();
        tick();
        #1;
        rst = 1;
        model_reset();
        d0 = bus.din[0];
        #1;
        checks++;
        if ({bus.gnt, bus.out_valid, bus.sel, bus.ack} !== 20'h0 || bus.out_data !== d0)
            $display("FAIL midreset: gnt/valid/sel/ack/data got %h/%b/%0d/%h/%h want 00/0/0/00/%h", bus.gnt, bus.out_valid, bus.sel, bus.ack, bus.out_data, d0);
        else passed++;
        @(negedge clk);
        rst = 0;
        bus.req = 8'h41;
        tick();
        #1;
        checks++;
        if (bus.gnt !== 8'h01) $display("FAIL midreset_restart: gnt got %h want 01", bus.gnt);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] r;
        do_reset();
        e_ack = '0;
        for (int c = 0; c < 400; c++) begin
            r = bus.req;
            for (int i = 0; i < 8; i++) begin
                if (r[i]) begin
                    if ((e_ack[i] && $urandom_range(1, 0) == 1) || $urandom_range(19, 0) == 0) r[i] = 0;
                end else if ($urandom_range(9, 0) < 3) begin
                    r[i] = 1;
                    bus.din[i] = W'($urandom);
                end
            end
            bus.req = r;
            bus.out_ready = $urandom_range(9, 0) < 7;
            settle();
            checks++;
            if ({bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data} !== {e_gnt, e_sel, e_valid, e_ack, e_data})
                $display("FAIL random_cycle%0d: gnt/sel/valid/ack/data got %h/%0d/%b/%h/%h want %h/%0d/%b/%h/%h", c, bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data, e_gnt, e_sel, e_valid, e_ack, e_data);
            else passed++;
            tick();
        end
    endtask

`ifdef MUX8_ARB_STATS_EN
    task automatic test_stats();
        int before;
        do_reset();
        stats_clr = 0;
        bus.req = 8'h01;
        bus.out_ready = 1;
        for (int c = 0; c < 60 && m_acc < 10; c++) tick();
        #1;
        checks++;
        if (beat_count !== 16'd10 || m_acc != 10) $display("FAIL stats_count: beat_count got %0d want 10 (model %0d)", beat_count, m_acc);
        else passed++;
        for (int c = 0; c < 10; c++) begin
            expect_now();
            if (e_valid) break;
            tick();
            #1;
        end
        before = m_acc;
        stats_clr = 1;
        tick();
        stats_clr = 0;
        #1;
        checks++;
        if (beat_count !== 16'd0 || m_acc != before + 1) $display("FAIL stats_clear: beat_count got %0d want 0 (accepted %0d)", beat_count, m_acc - before);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1;
        bus.req = '0;
        bus.out_ready = 0;
        bus.din = '0;
`ifdef MUX8_ARB_STATS_EN
        stats_clr = 0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_reset_mid();
        test_random();
`ifdef MUX8_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
